// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that shares one UART transmitter between NREQ byte requesters,
// frames the winning byte as an 11-bit even-parity packet and guards the handshake with a watchdog.
module uart_tx_scheduler #(
  parameter int NREQ       = 4,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   grant,
  output logic              startTransmit,
  output logic [10:0]       uart_packet,
  input  logic              transmitFinished,
  output logic              busy,
  output logic              timeout_err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] SEND = 2'd2;
  localparam logic [1:0] GAP  = 2'd3;

  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [15:0] GAP_LAST = 16'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [1:0]    state;
  logic [PW-1:0] rrPtr;
  logic [PW-1:0] winner;
  logic [PW-1:0] pick;
  logic          reqHit;
  logic [7:0]    pickData;
  logic [15:0]   toCnt;
  logic [15:0]   gapCnt;
  logic          endFrame;
  int            scanIdx;

  // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    pick    = '0;
    reqHit  = 1'b0;
    scanIdx = 0;
    for (int k = 0; k < NREQ; k++) begin
      scanIdx = int'(rrPtr) + k;
      if (scanIdx >= NREQ) scanIdx = scanIdx - NREQ;
      if (!reqHit && req[scanIdx[PW-1:0]]) begin
        reqHit = 1'b1;
        pick   = scanIdx[PW-1:0];
      end
    end
  end

  assign pickData = req_data[{pick, 3'b000} +: 8];
  assign endFrame = (state == SEND) && (transmitFinished || (toCnt == TO_LAST));

  // NOTE: all state and outputs use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rrPtr         <= '0;
      winner        <= '0;
      grant         <= '0;
      startTransmit <= 1'b0;
      uart_packet   <= 11'h7FF;
      busy          <= 1'b0;
      timeout_err   <= 1'b0;
      toCnt         <= '0;
      gapCnt        <= '0;
    end else begin
      grant       <= '0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (reqHit) begin
            winner      <= pick;
            grant       <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
            uart_packet <= {1'b1, ^pickData, pickData, 1'b0};
            busy        <= 1'b1;
            state       <= LOAD;
          end
        end
        LOAD: begin
          // Explicit wrap so non-power-of-two NREQ never lands on an unused index.
          rrPtr         <= (winner == PW'(NREQ - 1)) ? '0 : winner + 1'b1;
          toCnt         <= '0;
          startTransmit <= 1'b1;
          state         <= SEND;
        end
        SEND: begin
          toCnt <= toCnt + 16'd1;
          if (endFrame) begin
            startTransmit <= 1'b0;
            timeout_err   <= !transmitFinished;
            gapCnt        <= '0;
            state         <= (GAP_CYCLES == 0) ? IDLE : GAP;
            busy          <= (GAP_CYCLES != 0);
          end
        end
        default: begin
          gapCnt <= gapCnt + 16'd1;
          if (gapCnt == GAP_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
